// File: rtl/fp_div_sqrt_unit.sv
// fp_div_sqrt_unit: one-deep, iterative FP32 divide / square-root unit.
// Issue reserves it, exec sends operands, a fixed-latency restoring
// iteration produces 26 result bits, and the rounded result is held until
// exec releases it. Subnormal inputs are flushed to signed zero.
module fp_div_sqrt_unit #(
   parameter int ITER_PER_CYCLE = 1,
   parameter int ITER_BITS      = 26
) (
   input  logic        clk_i,
   input  logic        rst_ni,
   input  logic        acquire_i,
   input  logic        req_i,
   input  logic        release_i,
   input  logic        flush_i,
   input  logic        isDivide_i,
   input  logic [31:0] dataInA_i,
   input  logic [31:0] dataInB_i,
   input  logic [2:0]  rm_i,
   output logic        busy_o,
   output logic        reserved_o,
   output logic        finished_o,
   output logic [31:0] dataOut_o,
   output logic [4:0]  fflagsOut_o
);

   localparam int          N_CYC  = (ITER_BITS + ITER_PER_CYCLE - 1) / ITER_PER_CYCLE;
   localparam int          CNT_W  = $clog2(N_CYC + 1);
   localparam logic [31:0] QNAN   = 32'h7FC00000;
   localparam logic [2:0]  RM_RTZ = 3'd1;
   localparam logic [2:0]  RM_RDN = 3'd2;
   localparam logic [2:0]  RM_RUP = 3'd3;
   localparam logic [2:0]  RM_RMM = 3'd4;

   typedef enum logic [2:0] {
      S_FREE, S_RESERVED, S_UNPACK, S_ITER, S_ROUND, S_DONE
   } state_e;

   state_e             state_q;
   logic [CNT_W-1:0]   cnt_q;
   logic [31:0]        data_q;
   logic [4:0]         flags_q;

   // Operands latched on the accepted req, and the iteration datapath.
   logic               is_div_q, sign_q, special_q;
   logic [2:0]         rm_q;
   logic [31:0]        a_q, b_q, spec_res_q;
   logic [4:0]         spec_flags_q;
   logic signed [10:0] exp_q;
   logic [29:0]        rem_q;
   logic [25:0]        q_q;
   logic [51:0]        rad_q;

   // Operand classification (FTZ: any zero exponent counts as zero).
   logic [7:0]  ea, eb;
   logic [23:0] ma, mb;
   logic        a_zero, a_inf, a_nan, a_snan, b_zero, b_inf, b_nan, b_snan;
   logic signed [10:0] e_sq;

   assign ea     = a_q[30:23];
   assign eb     = b_q[30:23];
   assign ma     = {1'b1, a_q[22:0]};
   assign mb     = {1'b1, b_q[22:0]};
   assign a_zero = (ea == 8'h00);
   assign b_zero = (eb == 8'h00);
   assign a_inf  = (ea == 8'hFF) && (a_q[22:0] == '0);
   assign b_inf  = (eb == 8'hFF) && (b_q[22:0] == '0);
   assign a_nan  = (ea == 8'hFF) && (a_q[22:0] != '0);
   assign b_nan  = (eb == 8'hFF) && (b_q[22:0] != '0);
   assign a_snan = a_nan & ~a_q[22];
   assign b_snan = b_nan & ~b_q[22];
   assign e_sq   = $signed({3'b000, ea}) - 11'sd127;

   logic               spec_d, sign_d;
   logic [31:0]        spec_res_d;
   logic [4:0]         spec_flags_d;
   logic signed [10:0] exp_d;
   logic [29:0]        rem_init_d;
   logic [51:0]        rad_init_d;

   // Unpack: resolve special operands, compute the biased exponent and prime the remainder.
   always_comb begin
      // NOTE: every output gets a default first so no path leaves a latch behind.
      spec_d       = 1'b1;
      spec_res_d   = QNAN;
      spec_flags_d = 5'b00000;
      sign_d       = is_div_q ? (a_q[31] ^ b_q[31]) : a_q[31];
      if (is_div_q) begin
         if (a_nan | b_nan)                           spec_flags_d = {a_snan | b_snan, 4'b0000};
         else if ((a_zero & b_zero) | (a_inf & b_inf)) spec_flags_d = 5'b10000;
         else if (a_inf)                              spec_res_d   = {sign_d, 8'hFF, 23'b0};
         else if (b_zero) begin
            spec_res_d   = {sign_d, 8'hFF, 23'b0};
            spec_flags_d = 5'b01000;
         end
         else if (a_zero | b_inf)                     spec_res_d   = {sign_d, 31'b0};
         else                                         spec_d       = 1'b0;
         exp_d      = $signed({3'b000, ea}) - $signed({3'b000, eb}) + 11'sd127;
         rem_init_d = {6'b0, ma};
         rad_init_d = '0;
      end else begin
         if (a_nan)       spec_flags_d = {a_snan, 4'b0000};
         else if (a_zero) spec_res_d   = {a_q[31], 31'b0};
         else if (a_q[31]) spec_flags_d = 5'b10000;
         else if (a_inf)  spec_res_d   = 32'h7F800000;
         else             spec_d       = 1'b0;
         // Odd unbiased exponent: double the significand so the exponent halves exactly.
         exp_d      = (e_sq >>> 1) + 11'sd127;
         rem_init_d = '0;
         rad_init_d = e_sq[0] ? {ma, 28'b0} : {1'b0, ma, 27'b0};
      end
   end

   logic [29:0] rem_d, trial;
   logic [25:0] q_d;
   logic [51:0] rad_d;

   // Iterate: ITER_PER_CYCLE restoring steps of divide or digit-by-digit square root.
   always_comb begin
      rem_d = rem_q;
      q_d   = q_q;
      rad_d = rad_q;
      trial = '0;
      for (int i = 0; i < ITER_PER_CYCLE; i++) begin
         // NOTE: blocking assignments chain the steps within one cycle; state is committed with <= below.
         if (is_div_q) begin
            if (rem_d >= {6'b0, mb}) begin
               rem_d = rem_d - {6'b0, mb};
               q_d   = {q_d[24:0], 1'b1};
            end else begin
               q_d   = {q_d[24:0], 1'b0};
            end
            rem_d = {rem_d[28:0], 1'b0};
         end else begin
            rem_d = {rem_d[27:0], rad_d[51:50]};
            rad_d = {rad_d[49:0], 2'b00};
            trial = {2'b00, q_d, 2'b01};
            if (rem_d >= trial) begin
               rem_d = rem_d - trial;
               q_d   = {q_d[24:0], 1'b1};
            end else begin
               q_d   = {q_d[24:0], 1'b0};
            end
         end
      end
   end

   logic               hi, guard, rnd, sticky, inexact, inc, to_inf;
   logic [22:0]        frac_raw;
   logic [23:0]        frac_sum;
   logic signed [10:0] e_fin;
   logic [31:0]        res_d;
   logic [4:0]         flags_d;

   // Round: normalise on the quotient MSB, round by rm, detect overflow/underflow and pack.
   always_comb begin
      hi       = q_q[25];
      frac_raw = hi ? q_q[24:2] : q_q[23:1];
      guard    = hi ? q_q[1] : q_q[0];
      rnd      = hi & q_q[0];
      sticky   = |rem_q;
      inexact  = guard | rnd | sticky;
      case (rm_q)
         RM_RTZ:  inc = 1'b0;
         RM_RDN:  inc = sign_q & inexact;
         RM_RUP:  inc = ~sign_q & inexact;
         RM_RMM:  inc = guard;
         default: inc = guard & (rnd | sticky | frac_raw[0]);
      endcase
      frac_sum = {1'b0, frac_raw} + {23'b0, inc};
      e_fin    = exp_q - (hi ? 11'sd0 : 11'sd1) + (frac_sum[23] ? 11'sd1 : 11'sd0);
      to_inf   = (rm_q == RM_RDN) ? sign_q : (rm_q == RM_RUP) ? ~sign_q : (rm_q != RM_RTZ);
      if (special_q) begin
         res_d   = spec_res_q;
         flags_d = spec_flags_q;
      end else if (e_fin >= 11'sd255) begin
         res_d   = to_inf ? {sign_q, 8'hFF, 23'b0} : {sign_q, 31'h7F7FFFFF};
         flags_d = 5'b00101;
      end else if (e_fin <= 11'sd0) begin
         res_d   = {sign_q, 31'b0};
         flags_d = 5'b00011;
      end else begin
         res_d   = {sign_q, e_fin[7:0], frac_sum[22:0]};
         flags_d = {4'b0000, inexact};
      end
   end

   // Control FSM: handshake, iteration counter and the held result; flush overrides everything.
   always_ff @(posedge clk_i) begin
      if (!rst_ni) begin
         state_q <= S_FREE;
         cnt_q   <= '0;
         data_q  <= '0;
         flags_q <= '0;
      end else if (flush_i) begin
         state_q <= S_FREE;
         cnt_q   <= '0;
      end else begin
         case (state_q)
            S_FREE:     if (acquire_i) state_q <= S_RESERVED;
            S_RESERVED: if (req_i) state_q <= S_UNPACK;
            S_UNPACK: begin
               state_q <= S_ITER;
               cnt_q   <= CNT_W'(N_CYC);
            end
            S_ITER: begin
               cnt_q <= cnt_q - CNT_W'(1);
               if (cnt_q == CNT_W'(1)) state_q <= S_ROUND;
            end
            S_ROUND: begin
               state_q <= S_DONE;
               data_q  <= res_d;
               flags_q <= flags_d;
            end
            S_DONE:     if (release_i) state_q <= S_FREE;
            default:    state_q <= S_FREE;
         endcase
      end
   end

   // Datapath registers, loaded according to the current state.
   // NOTE: no reset here; each register is written before the FSM ever consumes it.
   always_ff @(posedge clk_i) begin
      case (state_q)
         S_RESERVED: if (req_i) begin
            is_div_q <= isDivide_i;
            a_q      <= dataInA_i;
            b_q      <= dataInB_i;
            rm_q     <= rm_i;
         end
         S_UNPACK: begin
            sign_q       <= sign_d;
            exp_q        <= exp_d;
            special_q    <= spec_d;
            spec_res_q   <= spec_res_d;
            spec_flags_q <= spec_flags_d;
            rem_q        <= rem_init_d;
            rad_q        <= rad_init_d;
            q_q          <= '0;
         end
         S_ITER: begin
            rem_q <= rem_d;
            rad_q <= rad_d;
            q_q   <= q_d;
         end
         default: ;
      endcase
   end

   assign busy_o      = (state_q != S_FREE);
   assign reserved_o  = (state_q == S_RESERVED);
   assign finished_o  = (state_q == S_DONE);
   assign dataOut_o   = data_q;
   assign fflagsOut_o = flags_q;

endmodule

// File: tb/tb_fp_div_sqrt_unit.sv
// Bench for fp_div_sqrt_unit: directed handshake/boundary cases plus random
// operands checked against an arithmetic reference model of FP32 div/sqrt.
module tb_fp_div_sqrt_unit;

   localparam int          IPC = 1;
   localparam int          LAT = 2 + (26 + IPC - 1) / IPC;
   localparam logic [31:0] QNAN = 32'h7FC00000;

   logic        clk = 1'b0, rst_n = 1'b0;
   logic        acquire = 1'b0, req = 1'b0, rel = 1'b0, flush = 1'b0, is_div = 1'b0;
   logic [31:0] a = '0, b = '0;
   logic [2:0]  rm = '0;
   logic        busy, reserved, finished;
   logic [31:0] data_out;
   logic [4:0]  fflags;
   int          n_checks = 0, n_fail = 0;

   always #5 clk = ~clk;

   fp_div_sqrt_unit #(.ITER_PER_CYCLE(IPC), .ITER_BITS(26)) dut (
      .clk_i(clk), .rst_ni(rst_n), .acquire_i(acquire), .req_i(req), .release_i(rel),
      .flush_i(flush), .isDivide_i(is_div), .dataInA_i(a), .dataInB_i(b), .rm_i(rm),
      .busy_o(busy), .reserved_o(reserved), .finished_o(finished),
      .dataOut_o(data_out), .fflagsOut_o(fflags)
   );

   task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
      n_checks++;
      if (got !== exp) begin
         n_fail++;
         $display("FAIL %s: got %0h expected %0h", tag, got, exp);
      end
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   // Exact integer square root, seeded from the real-valued sqrt.
   function automatic longint isqrt(input longint v);
      longint r;
      r = longint'($sqrt(real'(v)));
      while (r * r > v) r--;
      while ((r + 1) * (r + 1) <= v) r++;
      return r;
   endfunction

   // Reference: returns {fflags, result}.
   function automatic logic [36:0] ref_model(input logic d, input logic [31:0] x,
                                             input logic [31:0] y, input logic [2:0] mode);
      int     ex, ey, e_res, e_un, tail;
      logic   x_nan, x_snan, x_inf, x_zero, y_nan, y_snan, y_inf, y_zero;
      logic   sign, inexact, up, to_inf, odd;
      longint mx, my, num, q, rem, keep;
      ex = int'(x[30:23]);
      ey = int'(y[30:23]);
      x_nan  = (ex == 255) && (x[22:0] != 0);
      y_nan  = (ey == 255) && (y[22:0] != 0);
      x_snan = x_nan && !x[22];
      y_snan = y_nan && !y[22];
      x_inf  = (ex == 255) && (x[22:0] == 0);
      y_inf  = (ey == 255) && (y[22:0] == 0);
      x_zero = (ex == 0);
      y_zero = (ey == 0);
      mx = longint'({1'b1, x[22:0]});
      my = longint'({1'b1, y[22:0]});
      if (d) begin
         sign = x[31] ^ y[31];
         if (x_nan || y_nan) return {(x_snan || y_snan) ? 5'h10 : 5'h00, QNAN};
         if ((x_zero && y_zero) || (x_inf && y_inf)) return {5'h10, QNAN};
         if (x_inf) return {5'h00, sign, 8'hFF, 23'h0};
         if (y_zero) return {5'h08, sign, 8'hFF, 23'h0};
         if (x_zero || y_inf) return {5'h00, sign, 31'h0};
         num   = mx << 25;
         q     = num / my;
         rem   = num % my;
         e_res = ex - ey + 127;
         if (q < (longint'(1) << 25)) begin
            q     = q * 2;
            e_res = e_res - 1;
         end
      end else begin
         sign = x[31];
         if (x_nan) return {x_snan ? 5'h10 : 5'h00, QNAN};
         if (x_zero) return {5'h00, sign, 31'h0};
         if (sign) return {5'h10, QNAN};
         if (x_inf) return {5'h00, 32'h7F800000};
         e_un  = ex - 127;
         odd   = (e_un % 2) != 0;
         num   = odd ? (mx << 28) : (mx << 27);
         q     = isqrt(num);
         rem   = num - q * q;
         e_res = (odd ? e_un - 1 : e_un) / 2 + 127;
      end
      keep    = q / 4;
      tail    = int'(q % 4) * 2 + ((rem != 0) ? 1 : 0);   // 4 == exactly half an ulp
      inexact = (tail != 0);
      case (mode)
         3'd1:    up = 1'b0;
         3'd2:    up = sign && inexact;
         3'd3:    up = !sign && inexact;
         3'd4:    up = (tail >= 4);
         default: up = (tail > 4) || (tail == 4 && keep[0]);
      endcase
      keep = keep + (up ? 1 : 0);
      if (keep == (longint'(1) << 24)) begin
         keep  = keep / 2;
         e_res = e_res + 1;
      end
      if (e_res >= 255) begin
         to_inf = (mode == 3'd0) || (mode == 3'd4) || (mode == 3'd2 && sign) || (mode == 3'd3 && !sign);
         return {5'h05, sign, to_inf ? 31'h7F800000 : 31'h7F7FFFFF};
      end
      if (e_res <= 0) return {5'h03, sign, 31'h0};
      return {inexact ? 5'h01 : 5'h00, sign, 8'(e_res), keep[22:0]};
   endfunction

   function automatic logic [31:0] rand_fp();
      int          sel;
      logic        s;
      logic [22:0] f;
      sel = $urandom_range(0, 15);
      s   = 1'($urandom);
      f   = 23'($urandom);
      case (sel)
         0:       return {s, 31'h0};
         1:       return {s, 8'hFF, 23'h0};
         2:       return {s, 8'hFF, 1'b1, f[21:0]};
         3:       return {s, 8'hFF, 1'b0, f[21:1], 1'b1};
         4:       return {s, 8'h00, f | 23'h1};
         5:       return {s, 8'(($urandom_range(0, 1) != 0) ? $urandom_range(1, 4) : $urandom_range(250, 254)), f};
         6:       return {s, 8'($urandom_range(100, 154)), f[22:12], 12'h0};
         default: return {s, 8'($urandom_range(1, 254)), f};
      endcase
   endfunction

   task automatic issue(input logic d, input logic [31:0] x, input logic [31:0] y, input logic [2:0] mode);
      acquire = 1'b1;
      tick();
      acquire = 1'b0;
      req = 1'b1; is_div = d; a = x; b = y; rm = mode;
      tick();
      req = 1'b0;
   endtask

   task automatic wait_done(input string tag);
      int lat = 0;
      while (!finished && lat < 100) begin
         tick();
         lat++;
      end
      check({tag, "_latency"}, lat, LAT);
   endtask

   task automatic run_op(input string tag, input logic d, input logic [31:0] x, input logic [31:0] y,
                         input logic [2:0] mode, input logic [31:0] exp_res, input logic [4:0] exp_fl);
      issue(d, x, y, mode);
      wait_done(tag);
      check({tag, "_data"}, data_out, exp_res);
      check({tag, "_flags"}, fflags, exp_fl);
      rel = 1'b1;
      tick();
      rel = 1'b0;
      check({tag, "_busy_after_release"}, busy, 1'b0);
   endtask

   initial begin
      logic seen;
      tick();
      tick();
      check("reset_busy", busy, 1'b0);
      check("reset_reserved", reserved, 1'b0);
      check("reset_finished", finished, 1'b0);
      check("reset_data", data_out, 32'h0);
      check("reset_flags", fflags, 5'h0);
      rst_n = 1'b1;
      tick();

      run_op("div6_2",     1'b1, 32'h40C00000, 32'h40000000, 3'd0, 32'h40400000, 5'h00);
      run_op("div1_3_rne", 1'b1, 32'h3F800000, 32'h40400000, 3'd0, 32'h3EAAAAAB, 5'h01);
      run_op("div1_3_rtz", 1'b1, 32'h3F800000, 32'h40400000, 3'd1, 32'h3EAAAAAA, 5'h01);
      run_op("sqrt2",      1'b0, 32'h40000000, 32'h0,        3'd0, 32'h3FB504F3, 5'h01);
      run_op("sqrt_neg1",  1'b0, 32'hBF800000, 32'h0,        3'd0, QNAN,         5'h10);
      run_op("sqrt_neg0",  1'b0, 32'h80000000, 32'h0,        3'd0, 32'h80000000, 5'h00);
      run_op("sqrt_inf",   1'b0, 32'h7F800000, 32'h0,        3'd0, 32'h7F800000, 5'h00);
      run_op("div1_0",     1'b1, 32'h3F800000, 32'h00000000, 3'd0, 32'h7F800000, 5'h08);
      run_op("div0_0",     1'b1, 32'h00000000, 32'h80000000, 3'd0, QNAN,         5'h10);
      run_op("ovf_rne",    1'b1, 32'h7F7FFFFF, 32'h3E800000, 3'd0, 32'h7F800000, 5'h05);
      run_op("ovf_rtz",    1'b1, 32'h7F7FFFFF, 32'h3E800000, 3'd1, 32'h7F7FFFFF, 5'h05);

      // req while FREE must not start anything.
      req = 1'b1;
      tick();
      req = 1'b0;
      check("req_in_free_busy", busy, 1'b0);
      tick();
      check("req_in_free_finished", finished, 1'b0);

      // Delayed release: result held, acquire in DONE ignored, then release+acquire together.
      issue(1'b1, 32'h40C00000, 32'h40000000, 3'd0);
      wait_done("hold");
      acquire = 1'b1;
      for (int i = 0; i < 5; i++) begin
         tick();
         acquire = 1'b0;
         check("hold_data", data_out, 32'h40400000);
         check("hold_finished", finished, 1'b1);
      end
      check("acquire_in_done_reserved", reserved, 1'b0);
      rel = 1'b1;
      acquire = 1'b1;
      tick();
      rel = 1'b0;
      acquire = 1'b0;
      check("release_acquire_busy", busy, 1'b0);
      tick();
      check("release_acquire_reserved", reserved, 1'b0);

      // Flush at ITER cycle 10.
      issue(1'b1, 32'h3F800000, 32'h40400000, 3'd0);
      repeat (10) tick();
      flush = 1'b1;
      tick();
      flush = 1'b0;
      check("flush_busy", busy, 1'b0);
      seen = 1'b0;
      repeat (40) begin
         tick();
         if (finished) seen = 1'b1;
      end
      check("flush_no_finish", seen, 1'b0);
      run_op("after_flush", 1'b1, 32'h3F800000, 32'h40400000, 3'd0, 32'h3EAAAAAB, 5'h01);

      // Reset mid-ITER.
      issue(1'b0, 32'h40000000, 32'h0, 3'd0);
      repeat (6) tick();
      rst_n = 1'b0;
      tick();
      rst_n = 1'b1;
      check("midreset_busy", busy, 1'b0);
      check("midreset_data", data_out, 32'h0);
      check("midreset_flags", fflags, 5'h0);
      seen = 1'b0;
      repeat (40) begin
         tick();
         if (finished) seen = 1'b1;
      end
      check("midreset_no_finish", seen, 1'b0);
      run_op("after_reset", 1'b0, 32'h40000000, 32'h0, 3'd0, 32'h3FB504F3, 5'h01);

      // Random operands against the reference model.
      for (int k = 0; k < 150; k++) begin
         logic        d;
         logic [31:0] x, y;
         logic [2:0]  mode;
         logic [36:0] e;
         d    = 1'($urandom);
         x    = rand_fp();
         y    = rand_fp();
         mode = 3'($urandom_range(0, 4));
         if (!d && ($urandom_range(0, 3) != 0)) x[31] = 1'b0;
         e = ref_model(d, x, y, mode);
         run_op($sformatf("rnd%0d_%s_%h_%h_rm%0d", k, d ? "div" : "sqrt", x, y, mode),
                d, x, y, mode, e[31:0], e[36:32]);
      end

      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

   initial begin
      #2000000;
      $display("FAIL watchdog: simulation did not complete, checks %0d", n_checks);
      $fatal(1, "watchdog expired");
   end

endmodule

// File: doc/fp_div_sqrt_unit.md
Name: fp_div_sqrt_unit

Overview:
- Iterative FP32 divide / square-root unit attached to the FP execution stage.
- One-deep, shared resource. Issue reserves it, the execution stage sends operands, and the unit computes the result over a fixed number of cycles.
- The unit holds its result until the execution stage releases it at the final exec sub-stage.
- Recovery can abort the unit at any point.

Parameters:
ITER_PER_CYCLE, 1, quotient/root bits produced per cycle; legal values 1 or 2.
ITER_BITS, 26, mantissa result bits computed: 24 significand + guard + round.

Ports:
clk  in  1  clock
rst  in  1  reset; one clock; reset is synchronous and active-low
acquire  in  1  issue selected a div/sqrt op; reserve the unit
req  in  1  exec stage presents valid operands for the reserved op
release  in  1  exec stage consumed the result
flush  in  1  recovery flush of the in-flight div/sqrt op
isDivide  in  1  1 = A/B, 0 = sqrt(A); sampled on accepted req
dataInA  in  32  FP32 operand A; sampled on accepted req
dataInB  in  32  FP32 operand B; ignored for sqrt
rm  in  3  resolved rounding mode: RNE=0, RTZ=1, RDN=2, RUP=3, RMM=4; sampled on accepted req
busy  out  1  state != FREE; issue of div/sqrt ops is blocked
reserved  out  1  state == RESERVED
finished  out  1  state == DONE
dataOut  out  32  result; held stable while DONE
fflagsOut  out  5  {NV,DZ,OF,UF,NX}; held stable while DONE

Behaviour:
- FSM states: FREE, RESERVED, UNPACK, ITER, ROUND, DONE.
  - FREE: acquire -> RESERVED.
  - RESERVED: req -> UNPACK. Inputs are latched on this edge.
  - UNPACK (1 cycle): classify operands, align exponent, prime the remainder -> ITER.
  - ITER: lasts ceil(ITER_BITS/ITER_PER_CYCLE) cycles, tracked by a down-counter -> ROUND. The default is 26 cycles.
  - ROUND (1 cycle): normalize, round, pack -> DONE.
  - DONE: release -> FREE.
- Latency: finished rises exactly 2+ceil(26/ITER_PER_CYCLE) cycles after the req edge. With defaults this is 28 cycles.
  - Latency is identical for special-case operands. Special results are computed in UNPACK and carried through the pipeline.
- flush has priority over every other input in every state: next state is FREE and the counter clears.
- In FREE, flush and acquire in the same cycle gives FREE.
- acquire outside FREE is ignored. req outside RESERVED is ignored.
- release outside DONE is ignored. release and acquire in the same DONE cycle gives FREE; the acquire is dropped, and issue must retry since busy was high that cycle.
- Reset (rst=0): state FREE, counter 0, dataOut 0, fflagsOut 0. All status outputs are 0. Reset mid-operation discards the op.
- Division:
  - Restoring radix-2 on 24-bit significands.
  - Exponent = eA - eB + 127, adjusted by -1 if the quotient MSB is 0.
  - Sticky = (final remainder != 0).
- Sqrt:
  - Digit-by-digit restoring algorithm.
  - The exponent is made even by pre-shifting the significand.
  - Result exponent = (eA-127)/2 + 127.
  - Sticky as for division.
- Rounding: guard/round/sticky per rm.
  - Mantissa carry-out increments the exponent.
  - Exponent >= 255 gives overflow: ±Inf for RNE/RMM and directed modes toward the sign; otherwise ±0x7F7FFFFF. Sets OF|NX.
- Subnormals: subnormal inputs are treated as signed zero (flush-to-zero). A result exponent <= 0 yields signed zero with UF|NX.
- Special cases:
  - NaN operand gives 0x7FC00000. NV is set only for signalling NaN.
  - 0/0 and Inf/Inf give 0x7FC00000 with NV.
  - x/0 (x finite, non-zero) gives ±Inf with DZ.
  - sqrt(negative non-zero) gives 0x7FC00000 with NV.
  - sqrt(-0) = -0.
  - sqrt(+Inf) = +Inf.
  - x/Inf = ±0.
  - Sign of a divide = sA xor sB.
- NX is set when any of guard/round/sticky is non-zero.

Test Plan:
- Divide 0x40C00000 / 0x40000000, rm=RNE -> finished at req+28, dataOut 0x40400000, fflags 0. Release in DONE -> busy=0 next cycle.
- Divide 0x3F800000 / 0x40400000 -> RNE gives 0x3EAAAAAB with NX (0x01); RTZ gives 0x3EAAAAAA with NX.
- Sqrt 0x40000000, RNE -> 0x3FB504F3, NX. Sqrt 0xBF800000 -> 0x7FC00000, NV (0x10).
- Divide 0x3F800000 / 0x00000000 -> 0x7F800000, DZ (0x08). Divide 0x7F7FFFFF / 0x3E800000 under RNE -> 0x7F800000, OF|NX (0x05); under RTZ -> 0x7F7FFFFF.
- Flush asserted at ITER cycle 10 -> FREE next cycle, finished never rises. A following acquire/req computes correctly. Reset mid-ITER gives the same outcome.
- Handshake edges:
  - acquire while DONE is ignored.
  - req in FREE is ignored.
  - release+acquire in the same DONE cycle -> FREE.
  - dataOut is held stable for 5 cycles of delayed release.
